// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one multi-cycle single-port SRAM between IF (read-only) and MEM (read/write).
// Optional macro ARB_FAIR_EN: when defined, ties alternate between ports via last_owner;
// when undefined, MEM has fixed priority over IF.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t            state;
    logic [3:0]        cnt;
    logic              owner;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              grant_mem;

`ifdef ARB_FAIR_EN
    logic last_owner;
    assign grant_mem = mem_req && !(if_req && last_owner);
`else
    assign grant_mem = mem_req;
`endif

    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;

    // Arbitration FSM: grant in IDLE, count access cycles, pulse owner's ready in RESP
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            owner     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            sram_en   <= 1'b0;
            sram_we   <= 1'b0;
            busy      <= 1'b0;
`ifdef ARB_FAIR_EN
            last_owner <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req || if_req) begin
                        owner   <= grant_mem;
                        we_q    <= grant_mem && mem_we;
                        addr_q  <= grant_mem ? mem_addr : if_addr;
                        wdata_q <= grant_mem ? mem_wdata : '0;
                        cnt     <= CNT_INIT;
                        sram_en <= 1'b1;
                        sram_we <= grant_mem && mem_we;
                        busy    <= 1'b1;
                        state   <= ACCESS;
`ifdef ARB_FAIR_EN
                        last_owner <= grant_mem;
`endif
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        sram_en <= 1'b0;
                        sram_we <= 1'b0;
                        state   <= RESP;
                        if (owner) begin
                            mem_ready <= 1'b1;
                            if (!we_q) mem_rdata <= sram_rdata;
                        end else begin
                            if_ready <= 1'b1;
                            if (!we_q) if_rdata <= sram_rdata;
                        end
                    end
                end
                RESP: begin
                    if_ready  <= 1'b0;
                    mem_ready <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with SRAM model, directed scenarios and randomized dual-port traffic.
module tb_mem_port_arbiter;
    localparam int W = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
    logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
    logic [31:0] if_rdata, mem_rdata, sram_addr, sram_wdata, sram_rdata;
    logic        if_ready, mem_ready, sram_en, sram_we, busy;

    logic [31:0] sram    [0:2047];
    logic [31:0] ref_mem [0:2047];
    logic [31:0] q_if[$], q_mem[$];
    logic [31:0] exp_mem_rd = '0;
    int checks = 0, passes = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    assign sram_rdata = sram[sram_addr[12:2]];

    always @(posedge clk) if (sram_en && sram_we) sram[sram_addr[12:2]] <= sram_wdata;

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
    endtask

    task automatic push_if(input logic [31:0] a);
        q_if.push_back(ref_mem[a[12:2]]);
    endtask

    task automatic push_mem(input logic [31:0] a, input logic we, input logic [31:0] wd);
        if (we) ref_mem[a[12:2]] = wd;
        else exp_mem_rd = ref_mem[a[12:2]];
        q_mem.push_back(exp_mem_rd);
    endtask

    // Monitor: scoreboard pops on ready, access length, arbitration order
    int   run = 0;
    logic prev_en = 0, pif = 0, pmem = 0, last_g = 0, g;
    always @(negedge clk) begin
        if (!rst) begin
            run = 0; prev_en = 0; last_g = 0; pif = 0; pmem = 0;
        end else begin
            if (if_ready) begin
                if (q_if.size() == 0) chk("if_ready_unexpected", 1, 0);
                else chk("if_rdata", if_rdata, q_if.pop_front());
            end
            if (mem_ready) begin
                if (q_mem.size() == 0) chk("mem_ready_unexpected", 1, 0);
                else chk("mem_rdata", mem_rdata, q_mem.pop_front());
            end
            if (sram_we) chk("we_without_en", sram_en, 1);
            if (sram_en && !prev_en) begin
                g = sram_addr >= 32'h400;
                if (pif && pmem) begin
`ifdef ARB_FAIR_EN
                    chk("fair_grant", g, !last_g);
`else
                    chk("prio_grant", g, 1);
`endif
                end
                last_g = g;
            end
            if (sram_en) run++;
            else if (run != 0) begin
                chk("access_len", run, W);
                run = 0;
            end
            prev_en = sram_en; pif = if_req; pmem = mem_req;
        end
    end

    task automatic wait_rdy(input logic m);
        logic ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            ok = m ? mem_ready : if_ready;
        end
        if (!ok) chk(m ? "mem_timeout" : "if_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic dir_single(input logic m, input logic we, input logic [31:0] a, input logic [31:0] wd);
        if (m) begin
            mem_req = 1; mem_we = we; mem_addr = a; mem_wdata = wd; push_mem(a, we, wd);
        end else begin
            if_req = 1; if_addr = a; push_if(a);
        end
        for (int k = 0; k <= W + 1; k++) begin
            @(negedge clk);
            chk("en_seq", sram_en, k >= 1 && k <= W);
            chk("we_seq", sram_we, m && we && k >= 1 && k <= W);
            chk("rdy_seq", m ? mem_ready : if_ready, k == W + 1);
            chk("busy_seq", busy, k >= 1);
            if (k == 1) chk("sram_addr", sram_addr, a);
            if (k == 2 && m && we) chk("sram_wdata", sram_wdata, wd);
            if (k >= 1) begin if_addr = $urandom; mem_addr = $urandom; mem_wdata = $urandom; end
        end
        @(posedge clk); #1;
        mem_req = 0; if_req = 0;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin sram[i] = $urandom; ref_mem[i] = sram[i]; end
        sram[4] = 32'hE3A00001; ref_mem[4] = 32'hE3A00001;
        #1 rst = 0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_sram_en", sram_en, 0);
        chk("rst_sram_we", sram_we, 0);
        chk("rst_sram_addr", sram_addr, 0);
        chk("rst_if_ready", if_ready, 0);
        chk("rst_mem_ready", mem_ready, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_mem_rdata", mem_rdata, 0);
        @(negedge clk); rst = 1;
        @(posedge clk); #1;

        // MEM write, then IF read of the preloaded instruction word
        dir_single(1, 1, 32'h400, 32'hDEADBEEF);
        dir_single(0, 0, 32'h10, 32'h0);

        // Simultaneous requests: MEM first, IF follows after RESP
        if_req = 1; if_addr = 32'h20; push_if(32'h20);
        mem_req = 1; mem_we = 0; mem_addr = 32'h1004; push_mem(32'h1004, 0, 0);
        for (int k = 0; k <= 2 * W + 3; k++) begin
            @(negedge clk);
            chk("t3_mem_rdy", mem_ready, k == W + 1);
            chk("t3_if_rdy", if_ready, k == 2 * W + 3);
            @(posedge clk); #1;
            if (k == W + 1) mem_req = 0;
        end
        if_req = 0;

        // MEM drops req mid-access; IF must not reach the SRAM until RESP ends
        mem_req = 1; mem_we = 0; mem_addr = 32'h1008; push_mem(32'h1008, 0, 0);
        for (int k = 0; k <= 2 * W + 3; k++) begin
            @(negedge clk);
            chk("t6_mem_rdy", mem_ready, k == W + 1);
            chk("t6_if_rdy", if_ready, k == 2 * W + 3);
            chk("t6_en", sram_en, (k >= 1 && k <= W) || (k >= W + 3 && k <= 2 * W + 2));
            if (k == W + 3) chk("t6_if_addr", sram_addr, 32'h24);
            @(posedge clk); #1;
            if (k == 0) begin mem_req = 0; if_req = 1; if_addr = 32'h24; push_if(32'h24); end
        end
        if_req = 0;

        // Reset in the second ACCESS cycle abandons the transfer
        if_req = 1; if_addr = 32'h28;
        repeat (3) @(negedge clk);
        chk("t5_en_before", sram_en, 1);
        rst = 0;
        #1;
        chk("t5_en", sram_en, 0);
        chk("t5_we", sram_we, 0);
        chk("t5_busy", busy, 0);
        chk("t5_if_rdata", if_rdata, 0);
        chk("t5_mem_rdata", mem_rdata, 0);
        exp_mem_rd = 0;
        if_req = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t5_no_ready", {if_ready, mem_ready}, 0);
        end
        @(posedge clk); #1;
        dir_single(0, 0, 32'h2C, 32'h0);

        // Randomized concurrent traffic from both ports
        fork
            begin
                logic [31:0] ia;
                repeat (40) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    ia = 32'($urandom_range(0, 63)) * 4;
                    if_req = 1; if_addr = ia; push_if(ia);
                    wait_rdy(0);
                    if_req = 0; if_addr = $urandom;
                end
            end
            begin
                logic [31:0] ma, md;
                logic        mw;
                repeat (40) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    ma = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
                    mw = 1'($urandom_range(0, 1));
                    md = $urandom;
                    mem_req = 1; mem_we = mw; mem_addr = ma; mem_wdata = md; push_mem(ma, mw, md);
                    wait_rdy(1);
                    mem_req = 0; mem_addr = $urandom; mem_wdata = $urandom;
                end
            end
        join

        repeat (5) @(negedge clk);
        chk("q_if_drained", q_if.size(), 0);
        chk("q_mem_drained", q_mem.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
